ps2_key_sequencer: RTL and testbench

Controller that drains scan-code bytes from the `ps2_keyboard` receiver FIFO using its `ready`/`nextdata_n` handshake. It parses set-2 prefixes (`E0` extended, `F0` break) into single key events and presents them downstream on a valid/ready interface. It also tracks the held key, counts distinct presses and flags typematic repeats. It sits between `ps2_keyboard` and display/consumer logic in the digital-experiment keyboard path.

---
 rtl/ps2_key_sequencer.sv | 166 ++++++++++++++++
 tb/tb_ps2_key_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_sequencer.sv
// Drains scan-code bytes from the ps2_keyboard FIFO, folds E0/F0 prefixes into
// single key events, and presents them on a valid/ready port with held-key tracking.
module ps2_key_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             kb_ready,
    input  logic [7:0]       kb_data,
    input  logic             kb_overflow,
    output logic             kb_nextdata_n,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [7:0]       evt_code,
    output logic             evt_ext,
    output logic             evt_release,
    output logic             evt_repeat,
    output logic             key_down,
    output logic [CNT_W-1:0] press_count,
    output logic             overflow_sticky
);

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        EMIT
    } state_t;

    localparam logic [7:0] PFX_EXT = 8'hE0;
    localparam logic [7:0] PFX_BRK = 8'hF0;

    state_t           state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic             nextdata_n_q, nextdata_n_d;
    logic             ext_q, ext_d;
    logic             brk_q, brk_d;
    logic             held_v_q, held_v_d;
    logic [7:0]       held_code_q, held_code_d;
    logic             held_ext_q, held_ext_d;
    logic             evt_valid_q, evt_valid_d;
    logic [7:0]       evt_code_q, evt_code_d;
    logic             evt_ext_q, evt_ext_d;
    logic             evt_release_q, evt_release_d;
    logic             evt_repeat_q, evt_repeat_d;
    logic [CNT_W-1:0] press_count_q, press_count_d;
    logic             overflow_q, overflow_d;
    logic             held_match;
    logic             repeat_hit;

    // held_match compares the decoded byte against the held key, ignoring held_v.
    assign held_match = (held_code_q == byte_q) && (held_ext_q == ext_q);
    assign repeat_hit = !brk_q && held_v_q && held_match;

    always_comb begin
        state_d       = state_q;
        byte_d        = byte_q;
        nextdata_n_d  = nextdata_n_q;
        ext_d         = ext_q;
        brk_d         = brk_q;
        held_v_d      = held_v_q;
        held_code_d   = held_code_q;
        held_ext_d    = held_ext_q;
        evt_valid_d   = evt_valid_q;
        evt_code_d    = evt_code_q;
        evt_ext_d     = evt_ext_q;
        evt_release_d = evt_release_q;
        evt_repeat_d  = evt_repeat_q;
        press_count_d = press_count_q;
        overflow_d    = overflow_q | kb_overflow;

        case (state_q)
            IDLE: begin
                if (kb_ready) begin
                    byte_d       = kb_data;
                    nextdata_n_d = 1'b0;
                    state_d      = DECODE;
                end
            end
            DECODE: begin
                nextdata_n_d = 1'b1;
                if (byte_q == PFX_EXT) begin
                    ext_d   = 1'b1;
                    state_d = IDLE;
                end else if (byte_q == PFX_BRK) begin
                    brk_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    evt_code_d    = byte_q;
                    evt_ext_d     = ext_q;
                    evt_release_d = brk_q;
                    evt_repeat_d  = repeat_hit;
                    evt_valid_d   = 1'b1;
                    ext_d         = 1'b0;
                    brk_d         = 1'b0;
                    state_d       = EMIT;
                    if (!brk_q) begin
                        held_code_d = byte_q;
                        held_ext_d  = ext_q;
                        held_v_d    = 1'b1;
                        if (!repeat_hit) begin
                            press_count_d = press_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end else if (held_match) begin
                        held_v_d = 1'b0;
                    end
                end
            end
            EMIT: begin
                if (evt_ready) begin
                    evt_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            byte_q        <= 8'h00;
            nextdata_n_q  <= 1'b1;
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            held_v_q      <= 1'b0;
            held_code_q   <= 8'h00;
            held_ext_q    <= 1'b0;
            evt_valid_q   <= 1'b0;
            evt_code_q    <= 8'h00;
            evt_ext_q     <= 1'b0;
            evt_release_q <= 1'b0;
            evt_repeat_q  <= 1'b0;
            press_count_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_q        <= byte_d;
            nextdata_n_q  <= nextdata_n_d;
            ext_q         <= ext_d;
            brk_q         <= brk_d;
            held_v_q      <= held_v_d;
            held_code_q   <= held_code_d;
            held_ext_q    <= held_ext_d;
            evt_valid_q   <= evt_valid_d;
            evt_code_q    <= evt_code_d;
            evt_ext_q     <= evt_ext_d;
            evt_release_q <= evt_release_d;
            evt_repeat_q  <= evt_repeat_d;
            press_count_q <= press_count_d;
            overflow_q    <= overflow_d;
        end
    end

    assign kb_nextdata_n   = nextdata_n_q;
    assign evt_valid       = evt_valid_q;
    assign evt_code        = evt_code_q;
    assign evt_ext         = evt_ext_q;
    assign evt_release     = evt_release_q;
    assign evt_repeat      = evt_repeat_q;
    assign key_down        = held_v_q;
    assign press_count     = press_count_q;
    assign overflow_sticky = overflow_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed bench for ps2_key_sequencer: a small FIFO model stands in for
// ps2_keyboard and accepted events are compared against hand-computed values.
module tb_ps2_key_sequencer;

    logic       clk;
    logic       rst;
    logic       kbReady;
    logic [7:0] kbData;
    logic       kbOverflow;
    logic       kbNextdataN;
    logic       evtValid;
    logic       evtReady;
    logic [7:0] evtCode;
    logic       evtExt;
    logic       evtRelease;
    logic       evtRepeat;
    logic       keyDown;
    logic [7:0] pressCount;
    logic       overflowSticky;

    ps2_key_sequencer #(.CNT_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .kb_ready       (kbReady),
        .kb_data        (kbData),
        .kb_overflow    (kbOverflow),
        .kb_nextdata_n  (kbNextdataN),
        .evt_valid      (evtValid),
        .evt_ready      (evtReady),
        .evt_code       (evtCode),
        .evt_ext        (evtExt),
        .evt_release    (evtRelease),
        .evt_repeat     (evtRepeat),
        .key_down       (keyDown),
        .press_count    (pressCount),
        .overflow_sticky(overflowSticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keyboard FIFO model: pushes come from the stimulus, pops on a low strobe.
    logic [7:0] fifoMem [512];
    int wrPtr = 0;
    int rdPtr = 0;

    assign kbReady = (rdPtr != wrPtr);
    assign kbData  = fifoMem[rdPtr[8:0]];

    always @(posedge clk) begin
        if (!kbNextdataN && (rdPtr != wrPtr)) rdPtr <= rdPtr + 1;
    end

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       rel;
        logic       rep;
        logic       down;
        logic [7:0] cnt;
    } evt_t;

    evt_t evq[$];
    int   popCount = 0;
    int   dblLow   = 0;
    logic prevLow  = 1'b0;

    // Record accepted events and strobe statistics mid-cycle.
    always @(negedge clk) begin
        if (!kbNextdataN) popCount++;
        if (!kbNextdataN && prevLow) dblLow++;
        prevLow = !kbNextdataN;
        if (!rst && evtValid && evtReady)
            evq.push_back('{evtCode, evtExt, evtRelease, evtRepeat, keyDown, pressCount});
    end

    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        fifoMem[wrPtr[8:0]] = b;
        wrPtr = wrPtr + 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic waitIdle(input string tag, input int maxCycles);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < maxCycles) begin
            @(negedge clk);
            n++;
            if (rdPtr == wrPtr && !evtValid && kbNextdataN) quiet++;
            else quiet = 0;
        end
        if (quiet < 3) checkOutput({tag, "_idle_timeout"}, 32'd0, 32'd1);
        tick();
    endtask

    // Packed layout: {cnt, code, ext, rel, rep, down}.
    task automatic expectEvent(input string tag, input logic [7:0] code, input logic ext,
                               input logic rel, input logic rep, input logic down,
                               input logic [7:0] cnt);
        evt_t e;
        if (evq.size() == 0) begin
            checkOutput({tag, "_present"}, 32'd0, 32'd1);
        end else begin
            e = evq.pop_front();
            checkOutput(tag, {8'h00, e.cnt, e.code, e.ext, e.rel, e.rep, e.down},
                        {8'h00, cnt, code, ext, rel, rep, down});
        end
    endtask

    int p0;
    int pAt;
    int bad;

    initial begin
        rst        = 1'b1;
        evtReady   = 1'b1;
        kbOverflow = 1'b0;
        doReset();

        checkOutput("rst_strobe_valid", {30'd0, kbNextdataN, evtValid}, 32'h2);
        checkOutput("rst_event", {24'd0, evtCode}, 32'h0);
        checkOutput("rst_flags", {28'd0, evtExt, evtRelease, evtRepeat, keyDown}, 32'h0);
        checkOutput("rst_count_ovf", {23'd0, pressCount, overflowSticky}, 32'h0);

        // Make/break with cycle-accurate timing on the first byte.
        p0 = popCount;
        applyStimulus(8'h1C);
        @(negedge clk);
        checkOutput("t_cycN_strobe", {31'd0, kbNextdataN}, 32'd1);
        @(negedge clk);
        checkOutput("t_cycN1_strobe_valid", {30'd0, kbNextdataN, evtValid}, 32'h0);
        @(negedge clk);
        checkOutput("t_cycN2_valid_down_cnt", {22'd0, evtValid, keyDown, pressCount},
                    {22'd0, 1'b1, 1'b1, 8'd1});
        @(negedge clk);
        checkOutput("t_cycN3_valid", {31'd0, evtValid}, 32'd0);
        tick();
        applyStimulus(8'hF0);
        applyStimulus(8'h1C);
        waitIdle("mb", 100);
        expectEvent("mb_make", 8'h1C, 0, 0, 0, 1, 8'd1);
        expectEvent("mb_break", 8'h1C, 0, 1, 0, 0, 8'd1);
        checkOutput("mb_pops", popCount - p0, 32'd3);

        // Extended keys, both prefix orders.
        applyStimulus(8'hE0); applyStimulus(8'h75);
        applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75);
        applyStimulus(8'hF0); applyStimulus(8'hE0); applyStimulus(8'h75);
        waitIdle("ext", 200);
        expectEvent("ext_make", 8'h75, 1, 0, 0, 1, 8'd2);
        expectEvent("ext_break", 8'h75, 1, 1, 0, 0, 8'd2);
        expectEvent("ext_break_swapped", 8'h75, 1, 1, 0, 0, 8'd2);

        // Typematic repeats, foreign breaks and ext/non-ext aliasing.
        applyStimulus(8'h1C); applyStimulus(8'h1C); applyStimulus(8'h1C);
        applyStimulus(8'hF0); applyStimulus(8'h1C);
        applyStimulus(8'h32); applyStimulus(8'h1C);
        applyStimulus(8'hF0); applyStimulus(8'h32);
        applyStimulus(8'hF0); applyStimulus(8'h1C);
        applyStimulus(8'h1C); applyStimulus(8'hE0); applyStimulus(8'h1C);
        applyStimulus(8'hF0); applyStimulus(8'h1C);
        applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h1C);
        waitIdle("typ", 400);
        expectEvent("typ_make", 8'h1C, 0, 0, 0, 1, 8'd3);
        expectEvent("typ_rep1", 8'h1C, 0, 0, 1, 1, 8'd3);
        expectEvent("typ_rep2", 8'h1C, 0, 0, 1, 1, 8'd3);
        expectEvent("typ_break", 8'h1C, 0, 1, 0, 0, 8'd3);
        expectEvent("typ_other", 8'h32, 0, 0, 0, 1, 8'd4);
        expectEvent("typ_back", 8'h1C, 0, 0, 0, 1, 8'd5);
        expectEvent("typ_foreign_brk", 8'h32, 0, 1, 0, 1, 8'd5);
        expectEvent("typ_own_brk", 8'h1C, 0, 1, 0, 0, 8'd5);
        expectEvent("alias_plain", 8'h1C, 0, 0, 0, 1, 8'd6);
        expectEvent("alias_ext", 8'h1C, 1, 0, 0, 1, 8'd7);
        expectEvent("alias_plain_brk", 8'h1C, 0, 1, 0, 1, 8'd7);
        expectEvent("alias_ext_brk", 8'h1C, 1, 1, 0, 0, 8'd7);
        checkOutput("typ_extra", evq.size(), 32'd0);

        // Backpressure: first event must hold while three bytes wait upstream.
        evtReady = 1'b0;
        p0 = popCount;
        applyStimulus(8'h21); applyStimulus(8'h22); applyStimulus(8'h23);
        repeat (3) @(negedge clk);
        pAt = popCount;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!evtValid || evtCode !== 8'h21 || !kbNextdataN) bad++;
        end
        checkOutput("bp_first_pop", pAt - p0, 32'd1);
        checkOutput("bp_stable", bad, 32'd0);
        checkOutput("bp_no_pops", popCount - pAt, 32'd0);
        tick();
        evtReady = 1'b1;
        waitIdle("bp", 100);
        expectEvent("bp_ev1", 8'h21, 0, 0, 0, 1, 8'd8);
        expectEvent("bp_ev2", 8'h22, 0, 0, 0, 1, 8'd9);
        expectEvent("bp_ev3", 8'h23, 0, 0, 0, 1, 8'd10);

        // Counter wrap after 256 alternating-key makes.
        doReset();
        for (int i = 0; i < 255; i++) applyStimulus((i % 2 == 0) ? 8'h15 : 8'h16);
        waitIdle("wrap255", 3000);
        checkOutput("wrap_255", {24'd0, pressCount}, 32'd255);
        applyStimulus(8'h16);
        waitIdle("wrap0", 100);
        checkOutput("wrap_0_down", {23'd0, keyDown, pressCount}, {23'd0, 1'b1, 8'd0});
        evq.delete();

        // Reset after prefixes discards them.
        applyStimulus(8'hE0);
        applyStimulus(8'hF0);
        waitIdle("rstmid_pfx", 100);
        doReset();
        applyStimulus(8'h75);
        waitIdle("rstmid", 100);
        expectEvent("rstmid_make", 8'h75, 0, 0, 0, 1, 8'd1);

        // Overflow sticky flag.
        checkOutput("ovf_clear", {31'd0, overflowSticky}, 32'd0);
        kbOverflow = 1'b1;
        tick();
        kbOverflow = 1'b0;
        repeat (4) tick();
        checkOutput("ovf_sticky", {31'd0, overflowSticky}, 32'd1);
        doReset();
        checkOutput("ovf_rst", {31'd0, overflowSticky}, 32'd0);

        checkOutput("strobe_single_cycle", dblLow, 32'd0);
        checkOutput("final_extra", evq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
